// File: rtl/vit_pkg.sv
// Shared definitions for the Viterbi ACS scheduler: default trellis geometry,
// default ACS pipeline latency and the scheduler state type.
package vit_pkg;

   localparam int K_DEF       = 5;
   localparam int M_DEF       = K_DEF - 1;
   localparam int S_DEF       = 1 << M_DEF;
   localparam int ACS_LAT_DEF = 1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_INIT     = 3'd1,
      ST_ISWAP    = 3'd2,
      ST_WAIT_SYM = 3'd3,
      ST_ISSUE    = 3'd4,
      ST_DRAIN    = 3'd5,
      ST_SWAP     = 3'd6
   } sched_state_e;

endpackage

// File: rtl/vit_delay_line.sv
// Fixed-depth shift register that carries {valid, index} from the ACS read
// issue to the matching path-metric write. Flush empties every stage at once.
module vit_delay_line
   import vit_pkg::*;
#(
   parameter int DEPTH = ACS_LAT_DEF,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [DEPTH-1:0][W-1:0] pipe_q;

   // Shift one stage per cycle; flush drops everything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_q <= '0;
      end else if (flush_i) begin
         pipe_q <= '0;
      end else begin
         pipe_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/acs_sched.sv
// Add-compare-select step scheduler: sequences one trellis step per branch
// symbol, issues predecessor reads for every state, tracks the delayed
// path-metric writes and manages bank swaps and metric normalization.
module acs_sched
   import vit_pkg::*;
#(
   parameter int K       = K_DEF,
   parameter int M       = K - 1,
   parameter int S       = 1 << M,
   parameter int ACS_LAT = ACS_LAT_DEF,
   parameter int LEN_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] frame_len,
   input  logic             abort,
   input  logic             sym_valid,
   output logic             sym_ready,
   input  logic             norm_flag,
   output logic             init_frame,
   output logic             swap_banks,
   output logic [M-1:0]     rd_idx0,
   output logic [M-1:0]     rd_idx1,
   output logic             acs_valid,
   output logic [M-1:0]     acs_ns,
   output logic             wr_en,
   output logic [M-1:0]     wr_idx,
   output logic             norm_en,
   output logic             busy,
   output logic             step_done,
   output logic             frame_done
);

   sched_state_e     state_q, state_d;
   logic [M-1:0]     cnt_q, cnt_d;       // state index during ISSUE
   logic [2:0]       dcnt_q, dcnt_d;     // cycles spent in DRAIN
   logic [LEN_W-1:0] step_q, step_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] step_inc;
   logic             sticky_q, sticky_d; // any overflow seen this step
   logic             norm_en_q, norm_en_d;
   logic             abort_hit;
   logic [M:0]       dl_q;

   assign abort_hit = abort && (state_q != ST_IDLE);
   assign step_inc  = step_q + LEN_W'(1);
   assign busy      = (state_q != ST_IDLE);
   assign norm_en   = norm_en_q;

   // Next-state and output decode; abort overrides every other event.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dcnt_d     = dcnt_q;
      step_d     = step_q;
      len_d      = len_q;
      sticky_d   = sticky_q;
      norm_en_d  = norm_en_q;
      init_frame = 1'b0;
      swap_banks = 1'b0;
      step_done  = 1'b0;
      frame_done = 1'b0;
      sym_ready  = 1'b0;
      acs_valid  = 1'b0;
      acs_ns     = '0;
      rd_idx0    = '0;
      rd_idx1    = '0;

      // Overflow can be reported by any write of the step, including the
      // ones that land during DRAIN.
      if (state_q == ST_ISSUE || state_q == ST_DRAIN) begin
         sticky_d = sticky_q | norm_flag;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_INIT;
               len_d     = frame_len;
               step_d    = '0;
               cnt_d     = '0;
               dcnt_d    = '0;
               sticky_d  = 1'b0;
               norm_en_d = 1'b0;
            end
         end
         ST_INIT: begin
            init_frame = 1'b1;
            state_d    = ST_ISWAP;
         end
         ST_ISWAP: begin
            // Preloaded bank becomes the read bank for the first step.
            swap_banks = 1'b1;
            if (len_q == '0) begin
               frame_done = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               state_d = ST_WAIT_SYM;
            end
         end
         ST_WAIT_SYM: begin
            sym_ready = 1'b1;
            if (sym_valid) begin
               state_d = ST_ISSUE;
               cnt_d   = '0;
            end
         end
         ST_ISSUE: begin
            acs_valid = 1'b1;
            acs_ns    = cnt_q;
            rd_idx0   = cnt_q >> 1;
            rd_idx1   = (cnt_q >> 1) | M'(S / 2);
            cnt_d     = cnt_q + M'(1);
            if (cnt_q == M'(S - 1)) begin
               state_d = ST_DRAIN;
               dcnt_d  = '0;
            end
         end
         ST_DRAIN: begin
            dcnt_d = dcnt_q + 3'd1;
            if (dcnt_q == 3'(ACS_LAT - 1)) begin
               state_d = ST_SWAP;
            end
         end
         ST_SWAP: begin
            swap_banks = 1'b1;
            step_done  = 1'b1;
            step_d     = step_inc;
            norm_en_d  = sticky_q;
            sticky_d   = 1'b0;
            if (step_inc == len_q) begin
               frame_done = 1'b1;
               norm_en_d  = 1'b0;
               state_d    = ST_IDLE;
            end else begin
               state_d = ST_WAIT_SYM;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (abort_hit) begin
         state_d    = ST_IDLE;
         swap_banks = 1'b0;
         step_done  = 1'b0;
         frame_done = 1'b0;
         sticky_d   = 1'b0;
         norm_en_d  = 1'b0;
      end
   end

   // Scheduler registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         dcnt_q    <= '0;
         step_q    <= '0;
         len_q     <= '0;
         sticky_q  <= 1'b0;
         norm_en_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dcnt_q    <= dcnt_d;
         step_q    <= step_d;
         len_q     <= len_d;
         sticky_q  <= sticky_d;
         norm_en_q <= norm_en_d;
      end
   end

   vit_delay_line #(
      .DEPTH (ACS_LAT),
      .W     (M + 1)
   ) u_wr_dly (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (abort_hit),
      .d_i     ({acs_valid, acs_ns}),
      .q_o     (dl_q)
   );

   // A write still in the line when abort arrives is dropped too.
   assign wr_en  = dl_q[M] && !abort_hit;
   assign wr_idx = wr_en ? dl_q[M-1:0] : '0;

endmodule
